// File: rtl/savestate_sequencer_if.sv
// rtl/savestate_sequencer_if.sv - save state bus between core sequencer (master) and controller (slave)
interface savestate_sequencer_if;
    logic        ss_save;
    logic        ss_load;
    logic        ss_busy;
    logic        ss_req;
    logic        ss_rnw;
    logic [25:0] ss_addr;
    logic [7:0]  ss_be;
    logic [63:0] ss_dout;
    logic [63:0] ss_din;
    logic        ss_ack;

    modport master (
        input  ss_save, ss_load, ss_din, ss_ack,
        output ss_busy, ss_req, ss_rnw, ss_addr, ss_be, ss_dout
    );

    modport slave (
        output ss_save, ss_load, ss_din, ss_ack,
        input  ss_busy, ss_req, ss_rnw, ss_addr, ss_be, ss_dout
    );
endinterface

// File: rtl/savestate_sequencer.sv
// rtl/savestate_sequencer.sv - walks core state words over the save state bus for save and load
module savestate_sequencer #(
    parameter int unsigned WORD_COUNT   = 64,
    parameter logic [25:0] BASE_ADDR    = 26'h0,
    parameter logic [31:0] MAGIC        = 32'h4E45_5353,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned ACK_TIMEOUT  = 4096
) (
    input  logic                  clk_mem_85_9,
    input  logic                  reset,
    savestate_sequencer_if.master ss,
    output logic                  core_pause,
    output logic [15:0]           state_addr,
    output logic                  state_rd,
    input  logic [63:0]           state_rd_data,
    output logic                  state_wr,
    output logic [63:0]           state_wr_data,
    output logic                  load_err
);

    localparam logic [63:0] HEADER   = {MAGIC, 32'(WORD_COUNT)};
    localparam logic [16:0] LAST_IDX = 17'(WORD_COUNT);
    localparam logic [1:0]  LAT      = 2'(READ_LATENCY);

    typedef enum logic [3:0] {
        IDLE, SAVE_HDR, SAVE_FETCH, SAVE_REQ, WAIT_ACK,
        ACK_LOW, LOAD_REQ, LOAD_CHECK, LOAD_WRITE, FINISH
    } state_t;

    state_t      state_q, state_d;
    logic        save_q, load_q;
    logic [16:0] idx_q;
    logic [1:0]  lat_q;
    logic [31:0] to_q;
    logic [25:0] addr_q;
    logic [63:0] dout_q, din_q;
    logic        rnw_q, err_q;
    logic [15:0] sa_q;

    logic save_edge, load_edge;
    logic accept, advance, capture, set_err, latch;
    logic req_c, rd_c, wr_c;

    assign save_edge = ss.ss_save & ~save_q;
    assign load_edge = ss.ss_load & ~load_q;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        advance = 1'b0;
        capture = 1'b0;
        set_err = 1'b0;
        latch   = 1'b0;
        req_c   = 1'b0;
        rd_c    = 1'b0;
        wr_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_edge || save_edge) begin
                    accept  = 1'b1;
                    state_d = load_edge ? LOAD_REQ : SAVE_HDR;
                end
            end
            SAVE_HDR: state_d = SAVE_REQ;
            SAVE_FETCH: begin
                rd_c = (lat_q == 2'd0);
                if (lat_q == LAT) begin
                    latch   = 1'b1;
                    state_d = SAVE_REQ;
                end
            end
            SAVE_REQ: begin
                req_c   = 1'b1;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (ss.ss_ack) begin
                    capture = 1'b1;
                    state_d = ACK_LOW;
                end else if (to_q >= ACK_TIMEOUT) begin
                    set_err = 1'b1;
                    state_d = FINISH;
                end
            end
            ACK_LOW: begin
                // hold off the next request until the controller drops ack
                if (!ss.ss_ack) begin
                    advance = 1'b1;
                    if (!rnw_q)
                        state_d = (idx_q == LAST_IDX) ? FINISH : SAVE_FETCH;
                    else
                        state_d = (idx_q == 17'd0) ? LOAD_CHECK : LOAD_WRITE;
                end
            end
            LOAD_REQ: begin
                req_c   = 1'b1;
                state_d = WAIT_ACK;
            end
            LOAD_CHECK: begin
                if (din_q != HEADER) begin
                    set_err = 1'b1;
                    state_d = FINISH;
                end else begin
                    state_d = LOAD_REQ;
                end
            end
            LOAD_WRITE: begin
                wr_c    = 1'b1;
                state_d = (idx_q > LAST_IDX) ? FINISH : LOAD_REQ;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_mem_85_9) begin
        if (reset) begin
            state_q <= IDLE;
            // edge registers follow the input so a held trigger cannot fire on release
            save_q  <= ss.ss_save;
            load_q  <= ss.ss_load;
            idx_q   <= '0;
            lat_q   <= '0;
            to_q    <= '0;
            addr_q  <= '0;
            dout_q  <= '0;
            din_q   <= '0;
            rnw_q   <= 1'b1;
            err_q   <= 1'b0;
            sa_q    <= '0;
        end else begin
            state_q <= state_d;
            save_q  <= ss.ss_save;
            load_q  <= ss.ss_load;
            if (accept) begin
                idx_q  <= '0;
                addr_q <= BASE_ADDR;
                sa_q   <= '0;
                rnw_q  <= load_edge;
                err_q  <= 1'b0;
                lat_q  <= '0;
            end
            if (state_q == SAVE_HDR)
                dout_q <= HEADER;
            if (state_q == SAVE_FETCH) begin
                if (latch) begin
                    dout_q <= state_rd_data;
                    lat_q  <= '0;
                end else begin
                    lat_q <= lat_q + 2'd1;
                end
            end
            if (req_c)
                to_q <= 32'd1;
            else if (state_q == WAIT_ACK)
                to_q <= to_q + 32'd1;
            if (capture)
                din_q <= ss.ss_din;
            if (advance) begin
                idx_q  <= idx_q + 17'd1;
                addr_q <= addr_q + 26'd8;
                // save: index of the next word to fetch; load: index of the word just read
                if (!rnw_q)
                    sa_q <= idx_q[15:0];
                else if (idx_q != 17'd0)
                    sa_q <= idx_q[15:0] - 16'd1;
            end
            if (set_err)
                err_q <= 1'b1;
        end
    end

    assign ss.ss_busy    = (state_q != IDLE) && (state_q != FINISH);
    assign ss.ss_req     = req_c;
    assign ss.ss_rnw     = rnw_q;
    assign ss.ss_addr    = addr_q;
    assign ss.ss_be      = 8'hFF;
    assign ss.ss_dout    = dout_q;
    assign core_pause    = ss.ss_busy;
    assign state_addr    = sa_q;
    assign state_rd      = rd_c;
    assign state_wr      = wr_c;
    assign state_wr_data = din_q;
    assign load_err      = err_q;

endmodule

// File: doc/savestate_sequencer.md
# savestate_sequencer

Core-side initiator of the save state bus. It answers the `ss_save`/`ss_load` triggers from the save state controller and walks the core's internal state registers through a word-indexed local port. It issues one 64-bit `ss_req` transaction per word and raises `ss_busy` for the whole operation, so the controller can detect completion on its falling edge. It sits between the core's state register file and the PSRAM-backed save state controller, in the memory clock domain.

## Interface

Parameters:
- `WORD_COUNT`, default 64: number of 64-bit core state words, range 1..65535.
- `BASE_ADDR`, default 26'h0: byte address of the header word.
- `MAGIC`, default 32'h4E45_5353: header signature.
- `READ_LATENCY`, default 1: cycles from `state_rd` to valid `state_rd_data`, range 1..3.
- `ACK_TIMEOUT`, default 4096: cycles allowed between `ss_req` and `ss_ack` before abort.

Ports:
- `clk_mem_85_9`  in  1  single clock.
- `reset`  in  1  synchronous, active-high reset.
- `ss_save`  in  1  save trigger, level; acted on at its rising edge.
- `ss_load`  in  1  load trigger, level; acted on at its rising edge.
- `ss_busy`  out  1  high for the whole duration of an operation.
- `ss_req`  out  1  one-cycle request strobe.
- `ss_rnw`  out  1  1 = read from controller (load), 0 = write (save).
- `ss_addr`  out  26  byte address, 8-byte aligned.
- `ss_be`  out  8  constant 8'hFF.
- `ss_dout`  out  64  save data; valid on the `ss_req` cycle.
- `ss_din`  in  64  load data; valid on the first `ss_ack` cycle.
- `ss_ack`  in  1  completion; may stay high for several consecutive cycles.
- `core_pause`  out  1  freezes the core; equal to `ss_busy`.
- `state_addr`  out  16  core state word index (0..WORD_COUNT-1).
- `state_rd`  out  1  one-cycle read strobe.
- `state_rd_data`  in  64  core word, valid READ_LATENCY cycles after `state_rd`.
- `state_wr`  out  1  one-cycle write strobe.
- `state_wr_data`  out  64  data for `state_wr`.
- `load_err`  out  1  sticky; set on header mismatch or timeout.

## Operation

- Trigger detection: rising edge of a registered copy of `ss_save`/`ss_load`.
  - Both rising in the same cycle: load wins.
  - Triggers arriving while `ss_busy` is high are ignored.
  - Accepting a trigger clears `load_err`.
- Bus word index `i` maps to `ss_addr = BASE_ADDR + 8*i` (26-bit arithmetic, wraps modulo 2^26).
  - `i = 0` is the header `{MAGIC, WORD_COUNT[31:0]}`.
  - Core word `k` maps to `i = k+1`.
- States:
  - IDLE: waits for a trigger.
  - SAVE_HDR: loads the header into `ss_dout`, then goes to SAVE_REQ.
  - SAVE_FETCH: pulses `state_rd`, counts READ_LATENCY, latches `state_rd_data` into `ss_dout`.
  - SAVE_REQ: one-cycle `ss_req` with `ss_rnw=0`.
  - WAIT_ACK: accepts on the first cycle with `ss_ack=1`.
  - ACK_LOW: waits for `ss_ack=0`, then advances `i`.
  - LOAD_REQ: one-cycle `ss_req` with `ss_rnw=1`.
  - LOAD_CHECK: header compare.
  - LOAD_WRITE: pulses `state_wr` with `state_wr_data` = captured `ss_din`, `state_addr = i-1`.
  - FINISH: drops `ss_busy`, returns to IDLE.
- Save sequence: SAVE_HDR → SAVE_REQ → WAIT_ACK → ACK_LOW → then, for each `k`: SAVE_FETCH → SAVE_REQ → WAIT_ACK → ACK_LOW → … → FINISH.
- Load sequence: LOAD_REQ (i=0) → WAIT_ACK → ACK_LOW → LOAD_CHECK.
  - Header mismatch (either half): set `load_err`, go to FINISH; no `state_wr` is issued.
  - Header match: for each `k`, LOAD_REQ → WAIT_ACK → ACK_LOW → LOAD_WRITE.
- Timeout: in WAIT_ACK, a counter reaching ACK_TIMEOUT sets `load_err` and goes to FINISH. This applies to both save and load.
- The next `ss_req` is never issued while `ss_ack` is still high. This absorbs multi-cycle acks.

## Timing

- Reset values:
  - `ss_busy`, `core_pause`, `ss_req`, `state_rd`, `state_wr`, `load_err`: 0.
  - `ss_rnw`: 1.
  - `ss_addr`, `ss_dout`, `state_addr`, `state_wr_data`: 0.
  - `ss_be`: FF.
  - State: IDLE.
- `ss_busy` rises on the cycle after the trigger edge is detected, at most 2 cycles after the raw rise. This keeps it ahead of the controller's request phase.
- `ss_addr`, `ss_rnw` and `ss_dout` are stable from the `ss_req` cycle until the ack is accepted.
- Load data is captured on the first `ss_ack` cycle. `state_wr` follows 2 cycles later (ACK_LOW, then LOAD_WRITE, once ack is low).
- `ss_busy` falls one cycle after the last ACK_LOW/LOAD_WRITE, or on the cycle after an error. It then stays low for at least 1 cycle.
- Reset mid-operation: immediate return to IDLE with reset values. A trigger held high through reset does not fire, because the edge register resets to the current input.

## Test plan

- Save with WORD_COUNT=4, core words 64'h1111…, 2222…, 3333…, 4444…, and a responder that acks for 4 cycles → 5 `ss_req` pulses at addresses BASE+0, 8, 16, 24, 32, with `ss_dout` = header then the four words. `ss_busy` falls once; no duplicate requests.
- Load with a valid header and words A, B, C, D → `state_wr` at indices 0..3 with A..D; `load_err`=0.
- Load with header `MAGIC` ^ 1 → `load_err`=1, zero `state_wr` pulses, `ss_busy` low after 1 request.
- `ss_save` and `ss_load` rising in the same cycle → load sequence runs (`ss_rnw`=1). A second `ss_save` edge during busy is ignored.
- Responder never acks, ACK_TIMEOUT=16 → abort 16 cycles after `ss_req`, `load_err`=1, `ss_busy`=0.
- Reset asserted during the third WAIT_ACK → next cycle all outputs at reset values; a fresh save then starts cleanly at BASE+0.
